// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch reads and data accesses.
// Data has priority; a streak limit and a bus watchdog bound every wait.
module mem_arbiter #(
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  localparam int SW = (DATA_STREAK_MAX < 1) ? 1 : $clog2(DATA_STREAK_MAX + 1);
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wait_q, wait_d;

  logic          req_d, we_d;
  logic [31:0]   addr_d, wdata_d;
  logic          if_ack_d, mem_ack_d, err_d;
  logic [31:0]   if_rdata_d, mem_rdata_d;
  logic [31:0]   xfer_rdata;
  logic          data_win, fetch_win, timeout;

  // fetch only loses a tie while the data streak is under its limit
  assign data_win  = mem_req & (~if_req | (streak_q < STREAK_MAX));
  assign fetch_win = if_req & ~data_win;
  assign timeout   = (wait_q == WAIT_MAX);
  assign xfer_rdata = bus_ack ? bus_rdata : '0;

  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wait_d      = wait_q;
    req_d       = bus_req;
    we_d        = bus_we;
    addr_d      = bus_addr;
    wdata_d     = bus_wdata;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata;
    mem_rdata_d = mem_rdata;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          data_win: begin
            state_d = DATA;
            req_d   = 1'b1;
            we_d    = mem_we;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            if (!if_req)
              streak_d = '0;
            else if (streak_q != STREAK_MAX)
              streak_d = streak_q + 1'b1;
          end
          fetch_win: begin
            state_d  = FETCH;
            req_d    = 1'b1;
            we_d     = 1'b0;
            addr_d   = if_addr;
            wdata_d  = '0;
            streak_d = '0;
          end
          default: state_d = IDLE;
        endcase
      end
      FETCH, DATA: begin
        if (bus_ack || timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wait_d  = '0;
          err_d   = ~bus_ack;
          if (state_q == FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = xfer_rdata;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = xfer_rdata;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      wait_q    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      wait_q    <= wait_d;
      bus_req   <= req_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
      bus_err   <= err_d;
      if_ack    <= if_ack_d;
      mem_ack   <= mem_ack_d;
      if_rdata  <= if_rdata_d;
      mem_rdata <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int STREAK = 4;
  localparam int TMO    = 255;
  localparam int NEVER  = 100000;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_ack, if_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, mem_stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, bus_err;

  int passed = 0;
  int total  = 0;

  int          slave_lat = 0;
  int          slave_cnt = 0;
  logic        fixed_mode = 1'b0;
  logic [31:0] fixed_data = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_STREAK_MAX(STREAK),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ack(if_ack),
    .if_stall(if_stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .mem_stall(mem_stall),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .bus_err(bus_err)
  );

  // slave acks on bus cycle slave_lat (0 = first cycle)
  assign bus_ack   = bus_req && (slave_cnt == slave_lat);
  assign bus_rdata = fixed_mode ? fixed_data : (bus_addr ^ KEY);

  always @(posedge clk)
    slave_cnt <= (bus_req && !bus_ack) ? slave_cnt + 1 : 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst        = 1'b0;
    if_req     = 1'b0;
    if_addr    = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    slave_lat  = 0;
    fixed_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bit ld_ok, f_ok;
    logic pre_req;
    do_reset();
    ld_ok = 0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h80;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (mem_ack) begin mem_req = 0; ld_ok = 1; end
      @(negedge clk);
      if (ld_ok) break;
    end
    f_ok = 0;
    if_req = 1; if_addr = 32'h84;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (if_ack) begin if_req = 0; f_ok = 1; end
      @(negedge clk);
      if (f_ok) break;
    end
    total++;
    if ({ld_ok, f_ok} !== 2'b11)
      $display("FAIL rst_prep: got %b want 11", {ld_ok, f_ok});
    else passed++;
    slave_lat = NEVER;
    mem_req = 1; mem_we = 1;
    mem_addr = 32'h104; mem_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    pre_req = bus_req;
    total++;
    if (pre_req !== 1'b1)
      $display("FAIL rst_busy: got %b want 1", pre_req);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus_req, bus_we, if_ack, mem_ack, bus_err} !== 5'b0)
      $display("FAIL rst_ctl: got %b want 00000",
               {bus_req, bus_we, if_ack, mem_ack, bus_err});
    else passed++;
    total++;
    if ({bus_addr, bus_wdata, if_rdata, mem_rdata} !== 128'b0)
      $display("FAIL rst_data: got %h %h %h %h want 0",
               bus_addr, bus_wdata, if_rdata, mem_rdata);
    else passed++;
  endtask

  task automatic test_lone_fetch();
    int req_cyc, stall_cyc, ack_cyc, ack_at, bad_bus, mack;
    logic [31:0] got;
    do_reset();
    fixed_mode = 1; fixed_data = 32'h2408_0005;
    req_cyc = 0; stall_cyc = 0; ack_cyc = 0;
    ack_at = -1; bad_bus = 0; mack = 0; got = '0;
    if_req = 1; if_addr = 32'h40;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus_req) begin
        req_cyc++;
        if (bus_we !== 1'b0 || bus_addr !== 32'h40) bad_bus++;
      end
      if (if_stall) stall_cyc++;
      if (mem_ack) mack++;
      if (if_ack) begin
        ack_cyc++; ack_at = i; got = if_rdata; if_req = 0;
      end
      @(negedge clk);
    end
    total++;
    if (req_cyc != 1) $display("FAIL lf_busreq: got %0d want 1", req_cyc);
    else passed++;
    total++;
    if (bad_bus != 0) $display("FAIL lf_bus: got %0d bad want 0", bad_bus);
    else passed++;
    total++;
    if (stall_cyc != 2) $display("FAIL lf_stall: got %0d want 2", stall_cyc);
    else passed++;
    total++;
    if (ack_cyc != 1 || ack_at != 2)
      $display("FAIL lf_ack: got %0d@%0d want 1@2", ack_cyc, ack_at);
    else passed++;
    total++;
    if (got !== 32'h2408_0005)
      $display("FAIL lf_rdata: got %h want 24080005", got);
    else passed++;
    total++;
    if (mack != 0) $display("FAIL lf_mack: got %0d want 0", mack);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] g_addr[$], g_wd[$];
    logic g_we[$];
    logic prev_bus, fdone;
    int stall_bad, mack;
    logic [31:0] f_got;
    do_reset();
    prev_bus = 0; fdone = 0; stall_bad = 0; mack = 0; f_got = '0;
    mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h44;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus_req && !prev_bus) begin
        g_addr.push_back(bus_addr); g_wd.push_back(bus_wdata);
        g_we.push_back(bus_we);
      end
      prev_bus = bus_req;
      if (!fdone && !if_ack && if_stall !== 1'b1) stall_bad++;
      if (mem_ack) begin mack++; mem_req = 0; end
      if (if_ack) begin fdone = 1; f_got = if_rdata; if_req = 0; end
      @(negedge clk);
    end
    total++;
    if (g_we.size() != 2)
      $display("FAIL sim_grants: got %0d want 2", g_we.size());
    else begin
      passed++;
      total++;
      if ({g_we[0], g_addr[0], g_wd[0]} !== {1'b1, 32'h100, 32'hDEAD_BEEF})
        $display("FAIL sim_first: got %b %h %h want 1 100 deadbeef",
                 g_we[0], g_addr[0], g_wd[0]);
      else passed++;
      total++;
      if ({g_we[1], g_addr[1], g_wd[1]} !== {1'b0, 32'h44, 32'h0})
        $display("FAIL sim_second: got %b %h %h want 0 44 0",
                 g_we[1], g_addr[1], g_wd[1]);
      else passed++;
    end
    total++;
    if (stall_bad != 0) $display("FAIL sim_stall: got %0d drops want 0", stall_bad);
    else passed++;
    total++;
    if (mack != 1 || !fdone || f_got !== (32'h44 ^ KEY))
      $display("FAIL sim_acks: got %0d %b %h want 1 1 %h",
               mack, fdone, f_got, 32'h44 ^ KEY);
    else passed++;
  endtask

  task automatic test_starvation();
    bit owner[$];
    bit exp_own[6];
    logic prev_bus;
    int facks, pend_streak;
    bit fpend;
    do_reset();
    prev_bus = 0; facks = 0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h200;
    if_req = 1; if_addr = 32'h48;
    // reference: count back-to-back data grants while fetch waits
    pend_streak = 0; fpend = 1;
    for (int k = 0; k < 6; k++) begin
      if (fpend && pend_streak >= STREAK) begin
        exp_own[k] = 0; fpend = 0; pend_streak = 0;
      end else begin
        exp_own[k] = 1; pend_streak = fpend ? pend_streak + 1 : 0;
      end
    end
    for (int i = 0; i < 22; i++) begin
      #1;
      if (bus_req && !prev_bus) owner.push_back(bus_addr == 32'h200);
      prev_bus = bus_req;
      if (if_ack) begin facks++; if_req = 0; end
      @(negedge clk);
    end
    total++;
    if (owner.size() < 6)
      $display("FAIL stv_count: got %0d want >=6", owner.size());
    else begin
      passed++;
      for (int k = 0; k < 6; k++) begin
        total++;
        if (owner[k] !== exp_own[k])
          $display("FAIL stv_grant%0d: got data=%b want data=%b",
                   k, owner[k], exp_own[k]);
        else passed++;
      end
    end
    total++;
    if (facks != 1) $display("FAIL stv_fack: got %0d want 1", facks);
    else passed++;
  endtask

  task automatic test_timeout();
    int bus_cyc, ack_at, errs, f_at;
    logic [31:0] got, f_got;
    logic req_at_ack;
    do_reset();
    slave_lat = NEVER;
    bus_cyc = 0; ack_at = -1; errs = 0; f_at = -1;
    got = 32'hFFFF_FFFF; f_got = '0; req_at_ack = 1'b1;
    mem_req = 1; mem_we = 0; mem_addr = 32'h208;
    for (int i = 0; i < 320; i++) begin
      #1;
      if (bus_req && ack_at < 0) bus_cyc++;
      if (bus_err) errs++;
      if (mem_ack) begin
        ack_at = i; got = mem_rdata; req_at_ack = bus_req;
        mem_req = 0; slave_lat = 0;
        if_req = 1; if_addr = 32'h4C;
      end
      if (if_ack) begin f_at = i; f_got = if_rdata; if_req = 0; end
      @(negedge clk);
      if (f_at >= 0) break;
    end
    total++;
    if (bus_cyc != TMO + 1)
      $display("FAIL to_buscyc: got %0d want %0d", bus_cyc, TMO + 1);
    else passed++;
    total++;
    if (ack_at != TMO + 2)
      $display("FAIL to_ack_at: got %0d want %0d", ack_at, TMO + 2);
    else passed++;
    total++;
    if (got !== 32'h0 || req_at_ack !== 1'b0)
      $display("FAIL to_abort: got %h req=%b want 0 req=0", got, req_at_ack);
    else passed++;
    total++;
    if (errs != 1) $display("FAIL to_err: got %0d want 1", errs);
    else passed++;
    total++;
    if (f_at != ack_at + 2 || f_got !== (32'h4C ^ KEY))
      $display("FAIL to_next: got %0d %h want %0d %h",
               f_at, f_got, ack_at + 2, 32'h4C ^ KEY);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic busy, cut;
    int macks, g_cnt, ack_at;
    logic prev_bus, g_ok;
    do_reset();
    slave_lat = NEVER;
    mem_req = 1; mem_we = 1; mem_addr = 32'h300; mem_wdata = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    busy = bus_req;
    #2 rst = 1'b0;
    #1 cut = bus_req;
    total++;
    if ({busy, cut} !== 2'b10)
      $display("FAIL rmo_cut: got %b%b want 10", busy, cut);
    else passed++;
    macks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_ack) macks++;
    end
    @(negedge clk);
    slave_lat = 0;
    rst = 1'b1;
    prev_bus = 0; g_cnt = 0; g_ok = 0; ack_at = -1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus_req && !prev_bus) begin
        g_cnt++;
        g_ok = (bus_we === 1'b1) && (bus_addr === 32'h300) &&
               (bus_wdata === 32'hCAFE_F00D);
      end
      prev_bus = bus_req;
      if (mem_ack) begin ack_at = i; mem_req = 0; end
      @(negedge clk);
    end
    total++;
    if (macks != 0) $display("FAIL rmo_noack: got %0d want 0", macks);
    else passed++;
    total++;
    if (g_cnt != 1 || !g_ok)
      $display("FAIL rmo_regrant: got %0d ok=%b want 1 ok=1", g_cnt, g_ok);
    else passed++;
    total++;
    if (ack_at != 2) $display("FAIL rmo_ack: got %0d want 2", ack_at);
    else passed++;
  endtask

  task automatic test_slow_slave();
    int bus_cyc, unstable, acks, errs, ack_at;
    logic [31:0] wd;
    do_reset();
    slave_lat = 7;
    wd = $urandom;
    bus_cyc = 0; unstable = 0; acks = 0; errs = 0; ack_at = -1;
    mem_req = 1; mem_we = 1; mem_addr = 32'h304; mem_wdata = wd;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus_req) begin
        bus_cyc++;
        if (bus_addr !== 32'h304 || bus_wdata !== wd || bus_we !== 1'b1)
          unstable++;
      end
      if (bus_err) errs++;
      if (mem_ack) begin acks++; ack_at = i; mem_req = 0; end
      @(negedge clk);
    end
    total++;
    if (bus_cyc != 8) $display("FAIL ss_buscyc: got %0d want 8", bus_cyc);
    else passed++;
    total++;
    if (unstable != 0) $display("FAIL ss_stable: got %0d want 0", unstable);
    else passed++;
    total++;
    if (acks != 1 || ack_at != 9)
      $display("FAIL ss_ack: got %0d@%0d want 1@9", acks, ack_at);
    else passed++;
    total++;
    if (errs != 0) $display("FAIL ss_err: got %0d want 0", errs);
    else passed++;
  endtask

  task automatic test_random();
    int m_streak, pend_ack, owner;
    logic [31:0] pend_data, own_addr;
    logic prev_if, prev_mem, prev_bus;
    bit want_data;
    do_reset();
    m_streak = 0; pend_ack = 0; owner = 0; pend_data = '0; own_addr = '0;
    prev_if = 0; prev_mem = 0; prev_bus = 0;
    for (int i = 0; i < 3000; i++) begin
      #1;
      total++;
      if ({if_ack, mem_ack} !== {pend_ack == 1, pend_ack == 2})
        $display("FAIL rnd_ack@%0d: got %b%b want %b%b", i, if_ack, mem_ack,
                 pend_ack == 1, pend_ack == 2);
      else passed++;
      if (pend_ack == 1) begin
        total++;
        if (if_rdata !== pend_data)
          $display("FAIL rnd_irdata@%0d: got %h want %h", i, if_rdata, pend_data);
        else passed++;
      end
      if (pend_ack == 2) begin
        total++;
        if (mem_rdata !== pend_data)
          $display("FAIL rnd_mrdata@%0d: got %h want %h", i, mem_rdata, pend_data);
        else passed++;
      end
      total++;
      if ({if_stall, mem_stall, bus_err} !==
          {if_req & (pend_ack != 1), mem_req & (pend_ack != 2), 1'b0})
        $display("FAIL rnd_stall@%0d: got %b%b%b want %b%b0", i,
                 if_stall, mem_stall, bus_err,
                 if_req & (pend_ack != 1), mem_req & (pend_ack != 2));
      else passed++;
      pend_ack = 0;
      if (bus_req && !prev_bus) begin
        want_data = prev_mem && (!prev_if || m_streak < STREAK);
        if (want_data) begin
          owner = 2; own_addr = mem_addr;
          m_streak = prev_if ? ((m_streak < STREAK) ? m_streak + 1 : STREAK) : 0;
          total++;
          if ({bus_we, bus_addr, bus_wdata} !== {mem_we, mem_addr, mem_wdata})
            $display("FAIL rnd_dgrant@%0d: got %b %h %h want %b %h %h", i,
                     bus_we, bus_addr, bus_wdata, mem_we, mem_addr, mem_wdata);
          else passed++;
        end else begin
          owner = 1; own_addr = if_addr; m_streak = 0;
          total++;
          if ({prev_if, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b0, if_addr, 32'h0})
            $display("FAIL rnd_fgrant@%0d: got %b %h %h want 0 %h 0 (req %b)",
                     i, bus_we, bus_addr, bus_wdata, if_addr, prev_if);
          else passed++;
        end
      end
      prev_bus = bus_req;
      if (bus_req && bus_ack) begin
        pend_ack = owner; pend_data = own_addr ^ KEY;
      end
      if (!bus_req) slave_lat = $urandom_range(0, 3);
      if (if_ack) if_req = 0;
      if (mem_ack) mem_req = 0;
      if (!if_req && ($urandom % 10) < 4) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!mem_req && ($urandom % 10) < 5) begin
        mem_req = 1; mem_we = $urandom % 2;
        mem_addr = $urandom & 32'hFFFF_FFFC; mem_wdata = $urandom;
      end
      prev_if = if_req; prev_mem = mem_req;
      @(negedge clk);
    end
    if_req = 0; mem_req = 0;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = '0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    @(negedge clk);
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid_op();
    test_slow_slave();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
